// File: rtl/decoder_result_arbiter.sv
// decoder_result_arbiter: picks at most one qualified decoder result per cycle
// (add > cancel > delete), normalises it into a unified record and queues it in
// a first-word-fall-through FIFO behind a valid/ready interface. Saturating
// diagnostic counters track collisions, drops and invalidated strobes.
module decoder_result_arbiter #(
  parameter int DEPTH = 4,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     add_internal_valid,
  input  logic                     add_packet_invalid,
  input  logic [63:0]              add_order_ref,
  input  logic                     add_side,
  input  logic [31:0]              add_shares,
  input  logic [31:0]              add_price,
  input  logic [63:0]              add_stock_symbol,
  input  logic                     cancel_internal_valid,
  input  logic                     cancel_packet_invalid,
  input  logic [63:0]              cancel_order_ref,
  input  logic [31:0]              cancel_canceled_shares,
  input  logic                     delete_internal_valid,
  input  logic                     delete_packet_invalid,
  input  logic [63:0]              delete_order_ref,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [1:0]               out_type,
  output logic [63:0]              out_order_ref,
  output logic                     out_side,
  output logic [31:0]              out_shares,
  output logic [31:0]              out_price,
  output logic [63:0]              out_stock_symbol,
  output logic [$clog2(DEPTH):0]   fifo_level,
  output logic                     collision_err,
  output logic [CNT_W-1:0]         collision_count,
  output logic [CNT_W-1:0]         drop_count,
  output logic [CNT_W-1:0]         invalid_count
);

  localparam int PW    = $clog2(DEPTH);
  localparam int LW    = PW + 1;
  localparam int SW    = CNT_W + 1;
  localparam int REC_W = 2 + 64 + 1 + 32 + 32 + 64;
  localparam logic [LW-1:0]    FULL_LVL = LW'(DEPTH);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  logic             add_q, cancel_q, delete_q;
  logic [1:0]       n_qual;
  logic [1:0]       n_inval;
  logic             win;
  logic             collide;
  logic             push;
  logic             pop;
  logic [REC_W-1:0] win_rec;
  logic [REC_W-1:0] head_rec;
  logic [REC_W-1:0] mem [DEPTH];
  logic [PW-1:0]    wr_ptr;
  logic [PW-1:0]    rd_ptr;
  logic [LW-1:0]    level;

  // Counter increment that sticks at all-ones instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] c,
                                               input logic [1:0] inc);
    logic [SW-1:0] s;
    s = {1'b0, c} + SW'(inc);
    return s[CNT_W] ? CNT_MAX : s[CNT_W-1:0];
  endfunction

  // Qualify strobes and count how many decoders fired / were invalidated.
  always_comb begin
    add_q    = add_internal_valid    & ~add_packet_invalid;
    cancel_q = cancel_internal_valid & ~cancel_packet_invalid;
    delete_q = delete_internal_valid & ~delete_packet_invalid;
    n_qual   = {1'b0, add_q} + {1'b0, cancel_q} + {1'b0, delete_q};
    n_inval  = {1'b0, add_internal_valid & add_packet_invalid}
             + {1'b0, cancel_internal_valid & cancel_packet_invalid}
             + {1'b0, delete_internal_valid & delete_packet_invalid};
    win      = add_q | cancel_q | delete_q;
    collide  = (n_qual > 2'd1);
  end

  // Priority select and normalisation; fields a message type lacks are zero.
  always_comb begin
    win_rec = '0;
    if (add_q) begin
      win_rec = {2'b01, add_order_ref, add_side, add_shares, add_price, add_stock_symbol};
    end else if (cancel_q) begin
      win_rec = {2'b10, cancel_order_ref, 1'b0, cancel_canceled_shares, 32'd0, 64'd0};
    end else if (delete_q) begin
      win_rec = {2'b11, delete_order_ref, 1'b0, 32'd0, 32'd0, 64'd0};
    end
  end

  // A full FIFO still accepts a record when the head leaves in the same cycle;
  // the write then lands in the slot being vacated.
  assign out_valid = (level != '0);
  assign pop       = out_valid & out_ready;
  assign push      = win & ((level != FULL_LVL) | pop);
  assign head_rec  = out_valid ? mem[rd_ptr] : '0;
  assign {out_type, out_order_ref, out_side, out_shares, out_price, out_stock_symbol} = head_rec;
  assign fifo_level = level;

  // Record storage; contents need no reset because level gates the outputs.
  always_ff @(posedge clk) begin
    if (!rst && push) begin
      mem[wr_ptr] <= win_rec;
    end
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   level <= level + LW'(1);
        2'b01:   level <= level - LW'(1);
        default: level <= level;
      endcase
    end
  end

  // Saturating diagnostic counters and the sticky collision flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      collision_err   <= 1'b0;
      collision_count <= '0;
      drop_count      <= '0;
      invalid_count   <= '0;
    end else begin
      if (collide) begin
        collision_err   <= 1'b1;
        collision_count <= sat_add(collision_count, 2'd1);
      end
      if (win && !push) begin
        drop_count <= sat_add(drop_count, 2'd1);
      end
      if (n_inval != 2'd0) begin
        invalid_count <= sat_add(invalid_count, n_inval);
      end
    end
  end

endmodule
